// File: rtl/exec_ctrl_pkg.sv
// Shared widths and types for the Decode/Execute issue control slice.
package exec_ctrl_pkg;
    localparam int unsigned REG_IDX_W     = 5;
    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned DEF_CNT_W     = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// Per-register pending-write counter: up/down, holds at zero, sync clear.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

    // Retiring a write that was never issued means the pipeline lost track.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(dec && !inc && !clr && cnt_q == '0));
endmodule

// File: rtl/issue_scoreboard.sv
// RAW-hazard scoreboard and issue controller between Decode and Execute.
module issue_scoreboard
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_ARCH_REGS,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    output logic                dec_ready,
    input  reg_idx_t            dec_rs1,
    input  logic                dec_rs1_used,
    input  reg_idx_t            dec_rs2,
    input  logic                dec_rs2_used,
    input  reg_idx_t            dec_rd,
    input  logic                dec_rd_we,
    output logic                ex_valid,
    input  logic                wb_valid,
    input  reg_idx_t            wb_rd,
    input  logic                wb_rd_we,
    input  logic                wb_flush,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [PERF_W-1:0]   stall_cnt
);
    logic [CNT_W-1:0]  cnt [NUM_REGS];
    logic              hazard, full, issue;
    logic              ex_valid_d, ex_valid_q;
    logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q;

    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic inc_r, dec_r;
        assign inc_r = issue && dec_rd_we && dec_rd == REG_IDX_W'(r);
        assign dec_r = wb_valid && wb_rd_we && wb_rd == REG_IDX_W'(r);

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (wb_flush),
            .inc (inc_r),
            .dec (dec_r),
            .cnt (cnt[r])
        );
    end

    // Counts are the pre-update values: a same-cycle retire never unblocks issue.
    always_comb begin
        hazard    = (dec_rs1_used && dec_rs1 != '0 && cnt[dec_rs1] != '0)
                  | (dec_rs2_used && dec_rs2 != '0 && cnt[dec_rs2] != '0);
        full      = dec_rd_we && dec_rd != '0 && cnt[dec_rd] == '1;
        dec_ready = !wb_flush && !hazard && !full;
        issue     = dec_valid && dec_ready;
    end

    always_comb begin
        busy_vec = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            busy_vec[i] = cnt[i] != '0;
        end
    end

    always_comb begin
        ex_valid_d  = issue && !wb_flush;
        stall_cnt_d = stall_cnt_q;
        if (dec_valid && !dec_ready && !wb_flush && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with hand-computed expectations.
module tb_issue_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
    logic        dec_rs1_used, dec_rs2_used, dec_rd_we;
    logic        ex_valid, wb_valid, wb_rd_we, wb_flush;
    logic [31:0] busy_vec;
    logic [3:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    issue_scoreboard #(.NUM_REGS(32), .CNT_W(2), .PERF_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_rs1      (dec_rs1),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2      (dec_rs2),
        .dec_rs2_used (dec_rs2_used),
        .dec_rd       (dec_rd),
        .dec_rd_we    (dec_rd_we),
        .ex_valid     (ex_valid),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_rd_we     (wb_rd_we),
        .wb_flush     (wb_flush),
        .busy_vec     (busy_vec),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs1_used = 0; dec_rs2 = 0; dec_rs2_used = 0;
        dec_rd = 0; dec_rd_we = 0; wb_valid = 0; wb_rd = 0; wb_rd_we = 0; wb_flush = 0;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        idle();
        dec_valid = 1; dec_rd = rd; dec_rd_we = 1;
    endtask

    task automatic retire(input logic [4:0] rd);
        wb_valid = 1; wb_rd = rd; wb_rd_we = 1;
    endtask

    initial begin
        idle();
        rst = 0;
        #1;
        check_eq("reset_busy", busy_vec, 32'h0);
        check_eq("reset_exv", {31'b0, ex_valid}, 32'h0);
        check_eq("reset_stall", {28'b0, stall_cnt}, 32'h0);
        step(); step();
        rst = 1;
        step();

        // RAW on x5
        issue_rd(5); #1;
        check_eq("raw_first_ready", {31'b0, dec_ready}, 32'h1);
        step();
        check_eq("raw_exv", {31'b0, ex_valid}, 32'h1);
        check_eq("raw_busy5", busy_vec, 32'h0000_0020);
        idle(); dec_valid = 1; dec_rs1 = 5; dec_rs1_used = 1; #1;
        check_eq("raw_stall", {31'b0, dec_ready}, 32'h0);
        step();
        check_eq("raw_no_issue", {31'b0, ex_valid}, 32'h0);
        check_eq("raw_stall_cnt1", {28'b0, stall_cnt}, 32'h1);
        retire(5); #1;
        check_eq("raw_no_bypass", {31'b0, dec_ready}, 32'h0);
        step();
        wb_valid = 0; wb_rd_we = 0; #1;
        check_eq("raw_stall_cnt2", {28'b0, stall_cnt}, 32'h2);
        check_eq("raw_busy_clear", busy_vec, 32'h0);
        check_eq("raw_ready_after", {31'b0, dec_ready}, 32'h1);
        step();
        check_eq("raw_issue_exv", {31'b0, ex_valid}, 32'h1);

        // same-cycle retire + issue on x7
        issue_rd(7); step();
        issue_rd(7); retire(7); #1;
        check_eq("same_ready", {31'b0, dec_ready}, 32'h1);
        step();
        check_eq("same_busy7", busy_vec, 32'h0000_0080);
        check_eq("same_exv", {31'b0, ex_valid}, 32'h1);
        idle(); dec_valid = 1; dec_rs2 = 7; dec_rs2_used = 1; retire(7); #1;
        check_eq("same_rs2_stall", {31'b0, dec_ready}, 32'h0);
        step();
        idle(); #1;
        check_eq("same_stall_cnt", {28'b0, stall_cnt}, 32'h3);
        check_eq("same_busy_clear", busy_vec, 32'h0);

        // saturation of x3 at MAX=3
        for (int i = 0; i < 3; i++) begin
            issue_rd(3); #1;
            check_eq("sat_issue_ready", {31'b0, dec_ready}, 32'h1);
            step();
        end
        #1;
        check_eq("sat_full_stall", {31'b0, dec_ready}, 32'h0);
        check_eq("sat_busy3", busy_vec, 32'h0000_0008);
        step();
        check_eq("sat_stall_cnt4", {28'b0, stall_cnt}, 32'h4);
        check_eq("sat_no_issue", {31'b0, ex_valid}, 32'h0);
        retire(3); #1;
        check_eq("sat_retire_no_bypass", {31'b0, dec_ready}, 32'h0);
        step();
        idle(); dec_rd = 3; dec_rd_we = 1; #1;
        check_eq("sat_stall_cnt5", {28'b0, stall_cnt}, 32'h5);
        check_eq("sat_ready_again", {31'b0, dec_ready}, 32'h1);
        idle();
        for (int i = 0; i < 2; i++) begin
            retire(3); step();
        end
        idle(); #1;
        check_eq("sat_drained", busy_vec, 32'h0);

        // flush with pending writes
        issue_rd(4); step();
        issue_rd(9); step();
        issue_rd(9); step();
        idle(); #1;
        check_eq("flush_busy_pre", busy_vec, 32'h0000_0210);
        dec_valid = 1; dec_rd = 12; dec_rd_we = 1; wb_flush = 1; #1;
        check_eq("flush_ready", {31'b0, dec_ready}, 32'h0);
        step();
        idle(); #1;
        check_eq("flush_busy", busy_vec, 32'h0);
        check_eq("flush_exv", {31'b0, ex_valid}, 32'h0);
        check_eq("flush_no_stall", {28'b0, stall_cnt}, 32'h5);

        // x0 never tracked or hazarded
        idle(); dec_valid = 1; dec_rd_we = 1; dec_rs1_used = 1; dec_rs2_used = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("x0_ready", {31'b0, dec_ready}, 32'h1);
            step();
            check_eq("x0_busy", busy_vec, 32'h0);
        end
        retire(0); step();
        check_eq("x0_wb_busy", busy_vec, 32'h0);

        // stall counter saturation
        issue_rd(6); step();
        idle(); dec_valid = 1; dec_rs1 = 6; dec_rs1_used = 1;
        for (int i = 0; i < 10; i++) step();
        check_eq("perf_at_max", {28'b0, stall_cnt}, 32'hF);
        step(); step();
        check_eq("perf_saturated", {28'b0, stall_cnt}, 32'hF);
        idle(); retire(6); step();
        idle(); #1;
        check_eq("perf_busy_clear", busy_vec, 32'h0);

        // async reset mid-run with x5 pending twice
        issue_rd(5); step();
        issue_rd(5); step();
        idle(); #1;
        check_eq("rst_busy_pre", busy_vec, 32'h0000_0020);
        check_eq("rst_exv_pre", {31'b0, ex_valid}, 32'h1);
        rst = 0; #1;
        check_eq("rst_busy", busy_vec, 32'h0);
        check_eq("rst_exv", {31'b0, ex_valid}, 32'h0);
        check_eq("rst_stall", {28'b0, stall_cnt}, 32'h0);
        step();
        rst = 1;
        step();
        check_eq("rst_after_busy", busy_vec, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
